// File: rtl/decode_stage_param.sv
// Decode stage: opcode decode, register file with write-through bypass,
// immediate sign extension, and the decode->execute register with stall/flush.
module decode_stage_param #(
  parameter int unsigned DATA_W  = 19,
  parameter int unsigned PC_W    = 15,
  parameter int unsigned INSTR_W = 20,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NREGS   = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               valid_d,
  input  logic [INSTR_W-1:0] InstrD,
  input  logic [PC_W-1:0]    PCD,
  input  logic               RegWriteW,
  input  logic [REG_AW-1:0]  RdW,
  input  logic [DATA_W-1:0]  ResultW,
  output logic               valid_e,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic               JumpE,
  output logic               ALUSrcE,
  output logic               ResultSrcE,
  output logic               Cant_ByteE,
  output logic [1:0]         BranchE,
  output logic [2:0]         ALUControlE,
  output logic [DATA_W-1:0]  RD1E,
  output logic [DATA_W-1:0]  RD2E,
  output logic [DATA_W-1:0]  ImmExtE,
  output logic [PC_W-1:0]    PCE,
  output logic [REG_AW-1:0]  RDE,
  output logic [REG_AW-1:0]  RS1E,
  output logic [REG_AW-1:0]  RS2E
);

  typedef enum logic [1:0] {
    CAT_ALU_REG = 2'b00,
    CAT_ALU_IMM = 2'b01,
    CAT_MEM     = 2'b10,
    CAT_FLOW    = 2'b11
  } cat_e;

  cat_e              cat;
  logic [2:0]        fn;
  logic [REG_AW-1:0] rd, rs1, rs2;

  assign cat = cat_e'(InstrD[4:3]);
  assign fn  = InstrD[2:0];
  assign rd  = InstrD[9:5];
  assign rs1 = InstrD[14:10];
  assign rs2 = InstrD[19:15];

  logic              d_regwrite, d_memwrite, d_jump, d_alusrc, d_resultsrc, d_cant_byte;
  logic [1:0]        d_branch;
  logic [2:0]        d_aluctl;
  logic [DATA_W-1:0] d_imm;

  always_comb begin
    d_regwrite  = 1'b0;
    d_memwrite  = 1'b0;
    d_jump      = 1'b0;
    d_alusrc    = 1'b0;
    d_resultsrc = 1'b0;
    d_cant_byte = 1'b0;
    d_branch    = 2'b00;
    d_aluctl    = 3'b000;
    d_imm       = '0;
    case (cat)
      CAT_ALU_REG: begin
        d_regwrite = 1'b1;
        d_aluctl   = fn;
      end
      CAT_ALU_IMM: begin
        d_regwrite = 1'b1;
        d_alusrc   = 1'b1;
        d_aluctl   = fn;
        d_imm      = {{(DATA_W-5){InstrD[19]}}, InstrD[19:15]};
      end
      CAT_MEM: begin
        d_alusrc    = 1'b1;
        d_cant_byte = fn[1];
        if (fn[0]) begin
          d_memwrite = 1'b1;
          d_imm      = {{(DATA_W-5){InstrD[9]}}, InstrD[9:5]};
        end else begin
          d_regwrite  = 1'b1;
          d_resultsrc = 1'b1;
          d_imm       = {{(DATA_W-5){InstrD[19]}}, InstrD[19:15]};
        end
      end
      CAT_FLOW: begin
        case (fn)
          3'b000: begin
            d_jump = 1'b1;
            d_imm  = {{(DATA_W-15){InstrD[19]}}, InstrD[19:5]};
          end
          3'b001, 3'b010, 3'b011: begin
            d_branch = fn[1:0];
            d_aluctl = 3'b001;
            d_imm    = {{(DATA_W-10){InstrD[19]}}, InstrD[19:15], InstrD[9:5]};
          end
          default: ;
        endcase
      end
    endcase
  end

  // Register file; entry 0 exists but is never written so it stays zero.
  logic [DATA_W-1:0] regs [NREGS];
  logic              wb_ok;

  assign wb_ok = RegWriteW && (RdW != '0) && (int'(RdW) < int'(NREGS));

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_ok) begin
      regs[RdW] <= ResultW;
    end
  end

  logic [DATA_W-1:0] rd1, rd2;

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != '0 && int'(rs1) < int'(NREGS))
      rd1 = (wb_ok && RdW == rs1) ? ResultW : regs[rs1];
    if (rs2 != '0 && int'(rs2) < int'(NREGS))
      rd2 = (wb_ok && RdW == rs2) ? ResultW : regs[rs2];
  end

  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      valid_e     <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 1'b0;
      Cant_ByteE  <= 1'b0;
      BranchE     <= 2'b00;
      ALUControlE <= 3'b000;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      RDE         <= '0;
      RS1E        <= '0;
      RS2E        <= '0;
    end else if (!stall_i) begin
      // Data fields load regardless of valid_d; only control is gated.
      valid_e     <= valid_d;
      RegWriteE   <= valid_d & d_regwrite;
      MemWriteE   <= valid_d & d_memwrite;
      JumpE       <= valid_d & d_jump;
      ALUSrcE     <= valid_d & d_alusrc;
      ResultSrcE  <= valid_d & d_resultsrc;
      Cant_ByteE  <= valid_d & d_cant_byte;
      BranchE     <= valid_d ? d_branch : 2'b00;
      ALUControlE <= valid_d ? d_aluctl : 3'b000;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= d_imm;
      PCE         <= PCD;
      RDE         <= rd;
      RS1E        <= rs1;
      RS2E        <= rs2;
    end
  end

endmodule

// File: tb/tb_decode_stage_param.sv
// Bench for decode_stage_param: table-driven vectors plus stall/flush/reset
// sequences, expected E-register contents queued per cycle and compared.
module tb_decode_stage_param;

  logic        clk = 1'b0;
  logic        reset, stall_i, flush_i, valid_d, RegWriteW;
  logic [19:0] InstrD;
  logic [14:0] PCD;
  logic [4:0]  RdW;
  logic [18:0] ResultW;
  logic        valid_e, RegWriteE, MemWriteE, JumpE, ALUSrcE, ResultSrcE, Cant_ByteE;
  logic [1:0]  BranchE;
  logic [2:0]  ALUControlE;
  logic [18:0] RD1E, RD2E, ImmExtE;
  logic [14:0] PCE;
  logic [4:0]  RDE, RS1E, RS2E;

  decode_stage_param #(
    .DATA_W(19), .PC_W(15), .INSTR_W(20), .REG_AW(5), .NREGS(19)
  ) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .valid_d(valid_d), .InstrD(InstrD), .PCD(PCD), .RegWriteW(RegWriteW),
    .RdW(RdW), .ResultW(ResultW), .valid_e(valid_e), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .Cant_ByteE(Cant_ByteE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .RDE(RDE), .RS1E(RS1E), .RS2E(RS2E)
  );

  always #5 clk = ~clk;

  // ctl = {valid, regwrite, memwrite, jump, alusrc, resultsrc, cant_byte, branch[1:0], aluctl[2:0]}
  typedef struct packed {
    logic [11:0] ctl;
    logic [18:0] rd1, rd2, imm;
    logic [14:0] pc;
    logic [4:0]  rd, rs1, rs2;
  } out_t;

  typedef struct {
    string       name;
    bit          rst, stall, flush, vd;
    logic [19:0] instr;
    logic [14:0] pc;
    bit          rw;
    logic [4:0]  rdw;
    logic [18:0] resw;
    out_t        exp;
  } vec_t;

  out_t sb[$];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [11:0] c(bit v, bit rw, bit mw, bit j, bit as, bit rs, bit cb,
                                    logic [1:0] br, logic [2:0] alu);
    return {v, rw, mw, j, as, rs, cb, br, alu};
  endfunction

  function automatic logic [19:0] ins(logic [4:0] op, logic [4:0] rd, logic [4:0] rs1,
                                      logic [4:0] rs2);
    return {rs2, rs1, rd, op};
  endfunction

  function automatic out_t mk(logic [11:0] ctl, logic [18:0] rd1, logic [18:0] rd2,
                              logic [18:0] imm, logic [14:0] pc, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2);
    out_t o;
    o.ctl = ctl; o.rd1 = rd1; o.rd2 = rd2; o.imm = imm;
    o.pc = pc; o.rd = rd; o.rs1 = rs1; o.rs2 = rs2;
    return o;
  endfunction

  task automatic step(input vec_t v);
    out_t got, exp;
    reset = v.rst; stall_i = v.stall; flush_i = v.flush; valid_d = v.vd;
    InstrD = v.instr; PCD = v.pc; RegWriteW = v.rw; RdW = v.rdw; ResultW = v.resw;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    got = {valid_e, RegWriteE, MemWriteE, JumpE, ALUSrcE, ResultSrcE, Cant_ByteE,
           BranchE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, RDE, RS1E, RS2E};
    checks++;
    if (got !== exp)
      $display("FAIL %s: got ctl=%h rd1=%h rd2=%h imm=%h pc=%h rd=%0d rs1=%0d rs2=%0d, expected ctl=%h rd1=%h rd2=%h imm=%h pc=%h rd=%0d rs1=%0d rs2=%0d",
               v.name, got.ctl, got.rd1, got.rd2, got.imm, got.pc, got.rd, got.rs1, got.rs2,
               exp.ctl, exp.rd1, exp.rd2, exp.imm, exp.pc, exp.rd, exp.rs1, exp.rs2);
    else
      passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  out_t zero;
  out_t ea, eb;
  vec_t tv[12];
  vec_t v;

  initial begin
    zero = '0;
    ea = mk(c(1,1,0,0,0,0,0,2'b00,3'd5), 19'h12345, 19'h7FFFF, '0, 15'h200, 5'd9, 5'd3, 5'd18);
    eb = mk(c(1,1,0,0,1,0,0,2'b00,3'd0), 19'h11111, '0, '0, 15'h210, 5'd6, 5'd5, 5'd0);

    tv[0]  = '{"alu_reg_bypass", 1,0,0,1, ins(5'b00011,5'd4,5'd3,5'd0), 15'h100, 1, 5'd3, 19'h12345,
               mk(c(1,1,0,0,0,0,0,2'b00,3'd3), 19'h12345, '0, '0, 15'h100, 5'd4, 5'd3, 5'd0)};
    tv[1]  = '{"alu_imm", 1,0,0,1, ins(5'b01010,5'd5,5'd3,5'd15), 15'h101, 0, 5'd0, 19'h0,
               mk(c(1,1,0,0,1,0,0,2'b00,3'd2), 19'h12345, '0, 19'h0000F, 15'h101, 5'd5, 5'd3, 5'd15)};
    tv[2]  = '{"load_neg_imm", 1,0,0,1, ins(5'b10000,5'd1,5'd3,5'b11110), 15'h102, 1, 5'd30, 19'h7,
               mk(c(1,1,0,0,1,1,0,2'b00,3'd0), 19'h12345, '0, 19'h7FFFE, 15'h102, 5'd1, 5'd3, 5'd30)};
    tv[3]  = '{"store_byte", 1,0,0,1, ins(5'b10011,5'b10000,5'd3,5'd3), 15'h103, 1, 5'd18, 19'h00ABC,
               mk(c(1,0,1,0,1,0,1,2'b00,3'd0), 19'h12345, 19'h12345, 19'h7FFF0, 15'h103, 5'd16, 5'd3, 5'd3)};
    tv[4]  = '{"load_byte_r18", 1,0,0,1, ins(5'b10010,5'd2,5'd18,5'd1), 15'h104, 0, 5'd0, 19'h0,
               mk(c(1,1,0,0,1,1,1,2'b00,3'd0), 19'h00ABC, '0, 19'h00001, 15'h104, 5'd2, 5'd18, 5'd1)};
    tv[5]  = '{"jump_wr_r0", 1,0,0,1, ins(5'b11000,5'd0,5'd0,5'b10000), 15'h105, 1, 5'd0, 19'h5,
               mk(c(1,0,0,1,0,0,0,2'b00,3'd0), '0, '0, 19'h7C000, 15'h105, 5'd0, 5'd0, 5'd16)};
    tv[6]  = '{"beq_wr_r20", 1,0,0,1, ins(5'b11001,5'b11111,5'd0,5'd15), 15'h106, 1, 5'd20, 19'h7,
               mk(c(1,0,0,0,0,0,0,2'b01,3'd1), '0, '0, 19'h001FF, 15'h106, 5'd31, 5'd0, 5'd15)};
    tv[7]  = '{"bne_r20_byp2", 1,0,0,1, ins(5'b11010,5'd0,5'd20,5'd18), 15'h107, 1, 5'd18, 19'h7FFFF,
               mk(c(1,0,0,0,0,0,0,2'b10,3'd1), '0, 19'h7FFFF, 19'h7FE40, 15'h107, 5'd0, 5'd20, 5'd18)};
    tv[8]  = '{"blt", 1,0,0,1, ins(5'b11011,5'd1,5'd18,5'd0), 15'h108, 0, 5'd0, 19'h0,
               mk(c(1,0,0,0,0,0,0,2'b11,3'd1), 19'h7FFFF, '0, 19'h00001, 15'h108, 5'd1, 5'd18, 5'd0)};
    tv[9]  = '{"illegal_nop", 1,0,0,1, ins(5'b11111,5'd1,5'd3,5'd2), 15'h109, 0, 5'd0, 19'h0,
               mk(c(1,0,0,0,0,0,0,2'b00,3'd0), 19'h12345, '0, '0, 15'h109, 5'd1, 5'd3, 5'd2)};
    tv[10] = '{"invalid_d", 1,0,0,0, ins(5'b00001,5'd7,5'd3,5'd18), 15'h10A, 0, 5'd0, 19'h0,
               mk(12'h000, 19'h12345, 19'h7FFFF, '0, 15'h10A, 5'd7, 5'd3, 5'd18)};
    tv[11] = '{"flush", 1,0,1,1, ins(5'b01001,5'd3,5'd3,5'd3), 15'h10B, 0, 5'd0, 19'h0, zero};

    // Reset held two cycles under random stimulus
    for (int i = 0; i < 2; i++) begin
      v = '{"reset_hold", 0, 1'($urandom), 1'($urandom), 1'($urandom), 20'($urandom),
            15'($urandom), 1'($urandom), 5'($urandom), 19'($urandom), zero};
      step(v);
    end

    for (int i = 1; i < 19; i++) begin
      v = '{"read_after_reset", 1,0,0,1, ins(5'b00000, 5'(i), 5'(i), 5'(i)), 15'h0, 0, 5'd0, 19'h0,
            mk(c(1,1,0,0,0,0,0,2'b00,3'd0), '0, '0, '0, 15'h0, 5'(i), 5'(i), 5'(i))};
      step(v);
    end

    for (int i = 0; i < 12; i++) step(tv[i]);

    // Stall holds E while the register file still takes a write
    v = '{"stall_load", 1,0,0,1, ins(5'b00101,5'd9,5'd3,5'd18), 15'h200, 0, 5'd0, 19'h0, ea};
    step(v);
    for (int i = 0; i < 3; i++) begin
      v = '{"stall_hold", 1,1,0,1, 20'($urandom), 15'($urandom), i == 0, 5'd5, 19'h11111, ea};
      step(v);
    end
    v = '{"wr_during_stall", 1,0,0,1, ins(5'b01000,5'd6,5'd5,5'd0), 15'h210, 0, 5'd0, 19'h0, eb};
    step(v);
    v = '{"flush_over_stall", 1,1,1,1, ins(5'b00101,5'd9,5'd3,5'd18), 15'h220, 0, 5'd0, 19'h0, zero};
    step(v);

    // Reset during stall clears E and the register file
    v = '{"reload", 1,0,0,1, ins(5'b01000,5'd6,5'd5,5'd0), 15'h210, 0, 5'd0, 19'h0, eb};
    step(v);
    v = '{"reset_mid_stall", 0,1,0,1, ins(5'b00101,5'd9,5'd3,5'd18), 15'h230, 0, 5'd0, 19'h0, zero};
    step(v);
    v = '{"regs_cleared", 1,0,0,1, ins(5'b00000,5'd0,5'd3,5'd5), 15'h300, 0, 5'd0, 19'h0,
          mk(c(1,1,0,0,0,0,0,2'b00,3'd0), '0, '0, '0, 15'h300, 5'd0, 5'd3, 5'd5)};
    step(v);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
